// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder. A Start seen in IDLE captures A and B. The operands are
//   then added one bit per clock, LSB first, through a single full adder. The
//   sum register is loaded once, when the last bit has been added, so it never
//   shows a partial result.
//
// Ports
//   clk    in   1      single clock, rising edge
//   rst    in   1      synchronous active-high reset
//   Start  in   1      add request, sampled only in IDLE
//   A, B   in   WIDTH  addends, captured on the accepted Start edge
//   Busy   out  1      high during the WIDTH addition cycles (RUN)
//   Done   out  1      one-cycle pulse while Sum/Carry first hold a new result
//   Sum    out  WIDTH  registered (A+B) mod 2^WIDTH
//   Carry  out  1      registered carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] opA_q,      opA_d;
  logic [WIDTH-1:0] opB_q,      opB_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             carryInt_q, carryInt_d;
  logic [CW-1:0]    count_q,    count_d;
  logic [WIDTH-1:0] sum_q,      sum_d;
  logic             carryOut_q, carryOut_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;

  logic sumBit;
  logic carryNext;

  // One full-adder slice working on the current operand LSBs.
  assign sumBit    = opA_q[0] ^ opB_q[0] ^ carryInt_q;
  assign carryNext = (opA_q[0] & opB_q[0]) | (opA_q[0] & carryInt_q) |
                     (opB_q[0] & carryInt_q);

  // Next-state logic. Sum bits enter the result register at the MSB and
  // move down, so after WIDTH shifts the first computed bit sits at bit 0.
  // The final shift value is loaded directly into the output register on
  // the RUN->DONE edge, which is why sum_d uses the shifted value rather
  // than result_q.
  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    result_d   = result_q;
    carryInt_d = carryInt_q;
    count_d    = count_q;
    sum_d      = sum_q;
    carryOut_d = carryOut_q;

    case (state_q)
      IDLE: begin
        if (Start) begin
          opA_d      = A;
          opB_d      = B;
          result_d   = '0;
          carryInt_d = 1'b0;
          count_d    = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        opA_d      = opA_q >> 1;
        opB_d      = opB_q >> 1;
        carryInt_d = carryNext;
        result_d   = {sumBit, result_q[WIDTH-1:1]};
        count_d    = count_q + CNT_ONE;
        if (count_q == CNT_LAST) begin
          count_d    = '0;
          sum_d      = {sumBit, result_q[WIDTH-1:1]};
          carryOut_d = carryNext;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up
    // exactly with the state they describe.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State register; reset wins over everything, including a pending Start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      result_q   <= '0;
      carryInt_q <= 1'b0;
      count_q    <= '0;
      sum_q      <= '0;
      carryOut_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      result_q   <= result_d;
      carryInt_q <= carryInt_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      carryOut_q <= carryOut_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Sum   = sum_q;
  assign Carry = carryOut_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Directed bench for serial_adder. An 8-bit instance covers latency, Busy/
//   Done timing, ignored Start, reset mid-run and back-to-back operation. A
//   4-bit instance is swept over every operand pair against A+B.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8, carry8;
  logic [7:0] sum8;

  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4, carry4;
  logic [3:0] sum4;

  int compared   = 0;
  int mismatched = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .Start (start8),
    .A     (a8),
    .B     (b8),
    .Busy  (busy8),
    .Done  (done8),
    .Sum   (sum8),
    .Carry (carry8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .Start (start4),
    .A     (a4),
    .B     (b4),
    .Busy  (busy4),
    .Done  (done4),
    .Sum   (sum4),
    .Carry (carry4)
  );

  always #5 clk = ~clk;

  // Absolute run-time guard so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one clock and step just past the edge before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Checks made on every cycle the 8-bit adder should be in RUN: busy, no
  // Done, and the previous result still on the outputs.
  task automatic checkRun8(input string tag, input logic [7:0] holdSum,
                           input logic holdCarry);
    checkOutput({tag, "_busy"},  32'(busy8),  32'd1);
    checkOutput({tag, "_done"},  32'(done8),  32'd0);
    checkOutput({tag, "_hold_sum"},   32'(sum8),   32'(holdSum));
    checkOutput({tag, "_hold_carry"}, 32'(carry8), 32'(holdCarry));
  endtask

  // One complete 8-bit operation with Start pulsed for one cycle. Operands
  // are scrambled right after capture; optionally Start is re-pulsed with
  // new operands mid-run, which must be ignored.
  task automatic applyStimulus(input string tag, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] expSum,
                               input logic expCarry, input logic [7:0] holdSum,
                               input logic holdCarry, input bit rePulse);
    a8 = a; b8 = b; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = ~a; b8 = b ^ 8'hA5;
    for (int i = 0; i < 8; i++) begin
      checkRun8(tag, holdSum, holdCarry);
      if (rePulse && i == 3) begin
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
      end else begin
        start8 = 1'b0;
      end
      tick();
    end
    start8 = 1'b0;
    checkOutput({tag, "_done"},  32'(done8),  32'd1);
    checkOutput({tag, "_busy_in_done"}, 32'(busy8), 32'd0);
    checkOutput({tag, "_sum"},   32'(sum8),   32'(expSum));
    checkOutput({tag, "_carry"}, 32'(carry8), 32'(expCarry));
    tick();
    checkOutput({tag, "_done_pulse_end"}, 32'(done8), 32'd0);
    checkOutput({tag, "_idle_busy"},      32'(busy8), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    $display("[TB] serial_adder bench starting");

    tick();
    tick();
    checkOutput("reset_busy",  32'(busy8),  32'd0);
    checkOutput("reset_done",  32'(done8),  32'd0);
    checkOutput("reset_sum",   32'(sum8),   32'd0);
    checkOutput("reset_carry", 32'(carry8), 32'd0);
    rst = 1'b0;

    // Basic directed sums; each checks that the previous result is held.
    applyStimulus("add_5A_3C", 8'h5A, 8'h3C, 8'h96, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus("add_FF_01", 8'hFF, 8'h01, 8'h00, 1'b1, 8'h96, 1'b0, 1'b0);
    applyStimulus("add_FF_FF", 8'hFF, 8'hFF, 8'hFE, 1'b1, 8'h00, 1'b1, 1'b0);
    applyStimulus("add_00_00", 8'h00, 8'h00, 8'h00, 1'b0, 8'hFE, 1'b1, 1'b0);

    // Start re-pulsed during RUN must not change the result or queue work.
    applyStimulus("ignore_start", 8'h5A, 8'h3C, 8'h96, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("no_queued_busy", 32'(busy8), 32'd0);
      checkOutput("no_queued_done", 32'(done8), 32'd0);
    end
    checkOutput("no_queued_sum", 32'(sum8), 32'h96);

    // Reset on the 4th RUN cycle.
    a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("pre_reset_busy", 32'(busy8), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("mid_reset_busy",  32'(busy8),  32'd0);
    checkOutput("mid_reset_done",  32'(done8),  32'd0);
    checkOutput("mid_reset_sum",   32'(sum8),   32'd0);
    checkOutput("mid_reset_carry", 32'(carry8), 32'd0);
    // Reset beats Start on the same edge.
    start8 = 1'b1; a8 = 8'h77; b8 = 8'h77;
    tick();
    checkOutput("rst_prio_busy", 32'(busy8), 32'd0);
    checkOutput("rst_prio_done", 32'(done8), 32'd0);
    start8 = 1'b0;
    // First edge after reset release accepts Start.
    rst = 1'b0;
    applyStimulus("post_reset", 8'h01, 8'h02, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0);

    // Start held high: period of WIDTH+2 with one IDLE cycle between ops.
    begin
      logic [7:0] opsA [4];
      logic [7:0] opsB [4];
      logic [8:0] total;
      opsA = '{8'h12, 8'h80, 8'hC3, 8'h7F};
      opsB = '{8'h34, 8'h80, 8'h5E, 8'h01};
      start8 = 1'b1;
      a8 = opsA[0]; b8 = opsB[0];
      tick();
      for (int k = 0; k < 4; k++) begin
        a8 = 8'hEE; b8 = 8'hDD;
        for (int i = 0; i < 8; i++) begin
          checkOutput("b2b_busy", 32'(busy8), 32'd1);
          checkOutput("b2b_done_low", 32'(done8), 32'd0);
          tick();
        end
        total = {1'b0, opsA[k]} + {1'b0, opsB[k]};
        checkOutput("b2b_done",  32'(done8),  32'd1);
        checkOutput("b2b_sum",   32'(sum8),   32'(total[7:0]));
        checkOutput("b2b_carry", 32'(carry8), 32'(total[8]));
        if (k < 3) begin
          a8 = opsA[k+1]; b8 = opsB[k+1];
        end
        tick();
        checkOutput("b2b_idle_busy", 32'(busy8), 32'd0);
        checkOutput("b2b_idle_done", 32'(done8), 32'd0);
        if (k == 3) start8 = 1'b0;
        tick();
      end
      checkOutput("b2b_stop_busy", 32'(busy8), 32'd0);
    end

    // Exhaustive 4-bit sweep against a plain A+B reference.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        logic [4:0] ref4;
        ref4 = 5'(x) + 5'(y);
        a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int c = 0; c < 10 && !done4; c++) tick();
        checkOutput("w4_done",  32'(done4),  32'd1);
        checkOutput("w4_sum",   32'(sum4),   32'(ref4[3:0]));
        checkOutput("w4_carry", 32'(carry4), 32'(ref4[4]));
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 Start  input  1  request to add A and B; sampled only in IDLE.
REQ-005 A  input  WIDTH  addend; captured on the accepted Start edge only.
REQ-006 B  input  WIDTH  addend; captured on the accepted Start edge only.
REQ-007 Busy  output  1  high while the bit-serial addition is running (RUN state).
REQ-008 Done  output  1  one-cycle pulse marking the cycle that Sum/Carry first become valid.
REQ-009 Sum  output  WIDTH  registered result, A+B modulo 2^WIDTH.
REQ-010 Carry  output  1  registered carry out of bit WIDTH-1.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-012 IDLE with Start=1 SHALL latch A, B into shift registers, clear internal carry, set bit counter to 0, and go to RUN; Start=0 SHALL hold IDLE.
REQ-013 Each RUN cycle SHALL compute s = a0 ^ b0 ^ c and c' = (a0&b0)|(a0&c)|(b0&c) on the operand LSBs, shift both operands right by one, and shift s into the result register MSB-first-fill (LSB-first order).
REQ-014 RUN SHALL last exactly WIDTH cycles; on the cycle the counter reaches WIDTH-1, next state SHALL be DONE.
REQ-015 On RUN->DONE transition, Sum SHALL load the full result and Carry the final internal carry in the same edge.
REQ-016 DONE SHALL last one cycle with Done=1, then return to IDLE unconditionally.
REQ-017 Latency: Start accepted at edge N -> Done=1 and Sum/Carry valid during cycle N+WIDTH+1.
REQ-018 Sum and Carry SHALL hold their last result until the next completion; they SHALL NOT show partial values during RUN.
REQ-019 Start asserted in RUN or DONE SHALL be ignored (not queued); A/B changes after capture SHALL NOT affect the result.
REQ-020 Busy SHALL equal 1 exactly in RUN; Done SHALL equal 1 exactly in DONE; both never high together.
REQ-021 Counter width SHALL be ceil(log2(WIDTH)) bits minimum; no overflow for WIDTH=32.
REQ-022 Start held high continuously SHALL yield back-to-back operations with one IDLE cycle between DONE and the next RUN.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE, Busy=0, Done=0, Sum=0, Carry=0, clear operand/result registers and counter, regardless of state.
REQ-024 rst SHALL take priority over Start on the same edge; an operation interrupted by rst SHALL produce no Done pulse and leave Sum=0, Carry=0.
REQ-025 First Start SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-026 WIDTH=8, A=0x5A, B=0x3C, Start 1 cycle -> Busy high 8 cycles, then Done 1 cycle with Sum=0x96, Carry=0.
REQ-027 A=0xFF, B=0x01 -> Sum=0x00, Carry=1; A=0xFF, B=0xFF -> Sum=0xFE, Carry=1; A=0x00, B=0x00 -> Sum=0x00, Carry=0.
REQ-028 Start re-pulsed with A=0x11, B=0x22 during RUN of 0x5A+0x3C -> ignored; Sum=0x96, no second Done.
REQ-029 rst asserted on 4th RUN cycle -> next cycle IDLE, Busy=0, Sum=0x00, Carry=0, no Done; then 0x01+0x02 -> Sum=0x03.
REQ-030 Start held high, operands changing each op -> Done every WIDTH+2 cycles, each Sum matches its captured A+B; exhaustive random check vs. reference A+B for WIDTH=4 (all 256 pairs).
